// File: rtl/actor_mover_if.sv
// actor_mover_if: control/map inputs and motion outputs of one maze actor.
// master = game/AI side, slave = actor_mover.
interface actor_mover_if #(
  parameter int POS_W = 10
);
  logic             restart;
  logic             lifeDown;
  logic             freeze;
  logic [7:0]       keycode;
  logic [4:0]       mapL;
  logic [4:0]       mapR;
  logic [4:0]       mapB;
  logic [4:0]       mapT;
  logic [POS_W-1:0] posX;
  logic [POS_W-1:0] posY;
  logic [POS_W-1:0] size;
  logic [3:0]       dir_x;
  logic [3:0]       dir_y;
  logic             moving;
  logic             wrapped;

  modport master (
    output restart, lifeDown, freeze, keycode,
    output mapL, mapR, mapB, mapT,
    input  posX, posY, size, dir_x, dir_y,
    input  moving, wrapped
  );

  modport slave (
    input  restart, lifeDown, freeze, keycode,
    input  mapL, mapR, mapB, mapT,
    output posX, posY, size, dir_x, dir_y,
    output moving, wrapped
  );
endinterface

// File: rtl/actor_mover.sv
// actor_mover: per-frame maze actor motion (queued turns, fractional
// speed, tunnel wrap). Ports: frame_clk, Reset (async, high), bus (slave).
module actor_mover #(
  parameter int POS_W     = 10,
  parameter int X_START   = 202,
  parameter int Y_START   = 253,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 404,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 447,
  parameter int SIZE      = 13,
  parameter int SPEED_NUM = 1,
  parameter int SPEED_DEN = 1,
  parameter bit STICKY    = 1'b1,
  parameter int TUN_Y_LO  = 195,
  parameter int TUN_Y_HI  = 223,
  parameter int TUN_L     = 10,
  parameter int TUN_R     = 390,
  parameter int WRAP_L    = 15,
  parameter int WRAP_R    = 385
) (
  input  logic         frame_clk,
  input  logic         Reset,
  actor_mover_if.slave bus
);

  localparam int ACC_W = $clog2(SPEED_DEN) + 1;
  localparam int PW    = POS_W + 1;

  localparam logic [POS_W-1:0] X0  = POS_W'(X_START);
  localparam logic [POS_W-1:0] Y0  = POS_W'(Y_START);
  localparam logic [POS_W-1:0] TLO = POS_W'(TUN_Y_LO);
  localparam logic [POS_W-1:0] THI = POS_W'(TUN_Y_HI);
  localparam logic [POS_W-1:0] TL  = POS_W'(TUN_L);
  localparam logic [POS_W-1:0] TR  = POS_W'(TUN_R);
  localparam logic [POS_W-1:0] WL  = POS_W'(WRAP_L);
  localparam logic [POS_W-1:0] WR  = POS_W'(WRAP_R);

  localparam logic [PW-1:0] LIM_L = PW'(X_MIN + SIZE);
  localparam logic [PW-1:0] LIM_R = PW'(X_MAX);
  localparam logic [PW-1:0] LIM_U = PW'(Y_MIN + SIZE);
  localparam logic [PW-1:0] LIM_D = PW'(Y_MAX);
  localparam logic [PW-1:0] SZ    = PW'(SIZE);

  localparam logic [ACC_W-1:0] NUM_C = ACC_W'(SPEED_NUM);
  localparam logic [ACC_W-1:0] DEN_C = ACC_W'(SPEED_DEN);

  typedef enum logic [2:0] {
    D_NONE, D_L, D_R, D_U, D_D
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE, S_MOVE, S_BLOCK, S_RESP
  } state_e;

  logic [POS_W-1:0] posx_q, posx_d;
  logic [POS_W-1:0] posy_q, posy_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  dir_e             req_q, req_d;
  dir_e             cur_q, cur_d;
  state_e           st_q, st_d;
  logic [3:0]       dirx_q, dirx_d;
  logic [3:0]       diry_q, diry_d;
  logic             mov_q, mov_d;
  logic             wrp_q, wrp_d;

  dir_e             key_dir;
  dir_e             req_eff;
  dir_e             sel;
  logic             key_vld;
  logic             in_tun;
  logic             open_l, open_r, open_u, open_d;
  logic             wrap_l, wrap_r;
  logic [PW-1:0]    px, py;
  logic [ACC_W-1:0] acc_sum;

  function automatic logic dir_open(
    input dir_e d,
    input logic l,
    input logic r,
    input logic u,
    input logic dn
  );
    logic o;
    unique case (d)
      D_L:     o = l;
      D_R:     o = r;
      D_U:     o = u;
      D_D:     o = dn;
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  always_comb begin
    key_dir = D_NONE;
    unique case (bus.keycode)
      8'h04:   key_dir = D_L;
      8'h07:   key_dir = D_R;
      8'h16:   key_dir = D_D;
      8'h1A:   key_dir = D_U;
      default: key_dir = D_NONE;
    endcase
  end

  assign key_vld = (key_dir != D_NONE);
  assign req_eff = key_vld ? key_dir : req_q;

  // Zero-extended copies so bound sums cannot overflow.
  assign px     = {1'b0, posx_q};
  assign py     = {1'b0, posy_q};
  assign in_tun = (posy_q >= TLO) && (posy_q <= THI);

  // Horizontal bounds are waived inside the tunnel row.
  assign open_l = (bus.mapL == 5'd0) && (in_tun || px > LIM_L);
  assign open_r = (bus.mapR == 5'd0) && (in_tun || px + SZ < LIM_R);
  assign open_u = (bus.mapT == 5'd0) && (py > LIM_U);
  assign open_d = (bus.mapB == 5'd0) && (py + SZ < LIM_D);

  // Wrap looks at the registered direction and position.
  assign wrap_l = in_tun && (cur_q == D_L) && (posx_q <= TL);
  assign wrap_r = in_tun && (cur_q == D_R) && (posx_q >= TR);

  assign acc_sum = acc_q + NUM_C;

  always_comb begin
    posx_d = posx_q;
    posy_d = posy_q;
    acc_d  = acc_q;
    req_d  = req_q;
    cur_d  = cur_q;
    st_d   = st_q;
    dirx_d = dirx_q;
    diry_d = diry_q;
    mov_d  = 1'b0;
    wrp_d  = 1'b0;
    sel    = cur_q;
    if (bus.restart || bus.lifeDown) begin
      posx_d = X0;
      posy_d = Y0;
      acc_d  = '0;
      req_d  = D_NONE;
      cur_d  = D_NONE;
      st_d   = S_RESP;
    end else if (st_q == S_RESP) begin
      // One dead frame after respawn; keys and freeze ignored.
      st_d = S_IDLE;
    end else if (bus.freeze) begin
      req_d = req_eff;
    end else if (wrap_l) begin
      req_d  = req_eff;
      posx_d = WR;
      wrp_d  = 1'b1;
    end else if (wrap_r) begin
      req_d  = req_eff;
      posx_d = WL;
      wrp_d  = 1'b1;
    end else begin
      req_d = req_eff;
      if (req_eff != D_NONE &&
          dir_open(req_eff, open_l, open_r, open_u, open_d)) begin
        sel   = req_eff;
        req_d = D_NONE;
      end else if (!STICKY && !key_vld) begin
        sel = D_NONE;
      end
      cur_d = sel;
      if (sel == D_NONE) begin
        st_d = S_IDLE;
      end else if (!dir_open(sel, open_l, open_r, open_u, open_d)) begin
        st_d = S_BLOCK;
      end else begin
        st_d = S_MOVE;
        if (acc_sum >= DEN_C) begin
          acc_d = acc_sum - DEN_C;
          mov_d = 1'b1;
          unique case (sel)
            D_L: begin
              posx_d = posx_q - 1'b1;
              dirx_d = 4'd1;
              diry_d = 4'd2;
            end
            D_R: begin
              posx_d = posx_q + 1'b1;
              dirx_d = 4'd3;
              diry_d = 4'd2;
            end
            D_U: begin
              posy_d = posy_q - 1'b1;
              dirx_d = 4'd2;
              diry_d = 4'd1;
            end
            default: begin
              posy_d = posy_q + 1'b1;
              dirx_d = 4'd2;
              diry_d = 4'd3;
            end
          endcase
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      posx_q <= X0;
      posy_q <= Y0;
      acc_q  <= '0;
      req_q  <= D_NONE;
      cur_q  <= D_NONE;
      st_q   <= S_IDLE;
      dirx_q <= 4'd2;
      diry_q <= 4'd2;
      mov_q  <= 1'b0;
      wrp_q  <= 1'b0;
    end else begin
      posx_q <= posx_d;
      posy_q <= posy_d;
      acc_q  <= acc_d;
      req_q  <= req_d;
      cur_q  <= cur_d;
      st_q   <= st_d;
      dirx_q <= dirx_d;
      diry_q <= diry_d;
      mov_q  <= mov_d;
      wrp_q  <= wrp_d;
    end
  end

  assign bus.posX    = posx_q;
  assign bus.posY    = posy_q;
  assign bus.size    = POS_W'(SIZE);
  assign bus.dir_x   = dirx_q;
  assign bus.dir_y   = diry_q;
  assign bus.moving  = mov_q;
  assign bus.wrapped = wrp_q;

endmodule

// File: tb/tb_actor_mover.sv
// tb_actor_mover: two actors (1/1 sticky, 3/4 non-sticky) on one stimulus
// stream, checked frame by frame against a frame-level reference model.
module tb_actor_mover;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int mv;
    int wr;
    int ticks;
    int req;
    int cur;
    bit resp;
  } mst_t;

  typedef struct {
    bit       rs;
    bit       ld;
    bit       fz;
    bit [7:0] key;
    bit [4:0] ml;
    bit [4:0] mr;
    bit [4:0] mb;
    bit [4:0] mt;
  } in_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors = 0;
  int errs    = 0;
  int ncmp    = 0;

  mst_t m0, m1, e0, e1;
  mst_t q0[$];
  mst_t q1[$];
  in_t  cur_in;

  always #5 clk = ~clk;

  actor_mover_if #(.POS_W(10)) b0();
  actor_mover_if #(.POS_W(10)) b1();

  actor_mover u0 (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (b0)
  );

  actor_mover #(
    .SPEED_NUM (3),
    .SPEED_DEN (4),
    .STICKY    (1'b0)
  ) u1 (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (b1)
  );

  // Directions: 0 none, 1 left, 2 right, 3 up, 4 down.
  function automatic int keydir(input bit [7:0] k);
    case (k)
      8'h04:   return 1;
      8'h07:   return 2;
      8'h1A:   return 3;
      8'h16:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit mopen(input mst_t s, input in_t i, input int d);
    bit tun;
    tun = (s.y >= 195) && (s.y <= 223);
    case (d)
      1:       return (i.ml == 0) && (tun || s.x > 13);
      2:       return (i.mr == 0) && (tun || s.x + 13 < 404);
      3:       return (i.mt == 0) && (s.y > 13);
      4:       return (i.mb == 0) && (s.y + 13 < 447);
      default: return 1'b0;
    endcase
  endfunction

  function automatic mst_t minit();
    mst_t s;
    s.x = 202; s.y = 253; s.dx = 2; s.dy = 2;
    s.mv = 0; s.wr = 0; s.ticks = 0;
    s.req = 0; s.cur = 0; s.resp = 1'b0;
    return s;
  endfunction

  // One frame. The k-th open frame since a clear yields a pixel exactly
  // when floor(k*num/den) advances, which is the fractional speed rule.
  function automatic mst_t mstep(input mst_t s, input in_t i,
                                 input int num, input int den,
                                 input bit sticky);
    mst_t n;
    int   kd, re, sel;
    bit   tun;
    n = s;
    n.mv = 0;
    n.wr = 0;
    if (i.rs || i.ld) begin
      n.x = 202; n.y = 253; n.ticks = 0;
      n.req = 0; n.cur = 0; n.resp = 1'b1;
      return n;
    end
    if (s.resp) begin
      n.resp = 1'b0;
      return n;
    end
    kd = keydir(i.key);
    re = (kd != 0) ? kd : s.req;
    n.req = re;
    if (i.fz) return n;
    tun = (s.y >= 195) && (s.y <= 223);
    if (tun && s.cur == 1 && s.x <= 10) begin
      n.x = 385; n.wr = 1;
      return n;
    end
    if (tun && s.cur == 2 && s.x >= 390) begin
      n.x = 15; n.wr = 1;
      return n;
    end
    sel = s.cur;
    if (re != 0 && mopen(s, i, re)) begin
      sel = re;
      n.req = 0;
    end else if (!sticky && kd == 0) begin
      sel = 0;
    end
    n.cur = sel;
    if (sel != 0 && mopen(s, i, sel)) begin
      if (((s.ticks + 1) * num) / den != (s.ticks * num) / den) begin
        n.mv = 1;
        case (sel)
          1: begin n.x = s.x - 1; n.dx = 1; n.dy = 2; end
          2: begin n.x = s.x + 1; n.dx = 3; n.dy = 2; end
          3: begin n.y = s.y - 1; n.dx = 2; n.dy = 1; end
          default: begin n.y = s.y + 1; n.dx = 2; n.dy = 3; end
        endcase
      end
      n.ticks = s.ticks + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    b0.restart = i.rs;  b1.restart = i.rs;
    b0.lifeDown = i.ld; b1.lifeDown = i.ld;
    b0.freeze = i.fz;   b1.freeze = i.fz;
    b0.keycode = i.key; b1.keycode = i.key;
    b0.mapL = i.ml;     b1.mapL = i.ml;
    b0.mapR = i.mr;     b1.mapR = i.mr;
    b0.mapB = i.mb;     b1.mapB = i.mb;
    b0.mapT = i.mt;     b1.mapT = i.mt;
    m0 = mstep(m0, i, 1, 1, 1'b1);
    m1 = mstep(m1, i, 3, 4, 1'b0);
    q0.push_back(m0);
    q1.push_back(m1);
    vectors++;
  endtask

  task automatic apply(input bit rs, input bit ld, input bit fz,
                       input bit [7:0] key,
                       input bit [4:0] ml, input bit [4:0] mr,
                       input bit [4:0] mb, input bit [4:0] mt);
    in_t i;
    i.rs = rs; i.ld = ld; i.fz = fz; i.key = key;
    i.ml = ml; i.mr = mr; i.mb = mb; i.mt = mt;
    @(negedge clk);
    drive(i);
  endtask

  task automatic check_reset();
    chk("rst.u0.posX", int'(b0.posX), 202);
    chk("rst.u0.posY", int'(b0.posY), 253);
    chk("rst.u0.dir_x", int'(b0.dir_x), 2);
    chk("rst.u0.dir_y", int'(b0.dir_y), 2);
    chk("rst.u0.moving", int'(b0.moving), 0);
    chk("rst.u0.wrapped", int'(b0.wrapped), 0);
    chk("rst.u1.posX", int'(b1.posX), 202);
    chk("rst.u1.posY", int'(b1.posY), 253);
    chk("rst.u1.moving", int'(b1.moving), 0);
  endtask

  // Async pulse between edges; outputs must settle without a clock.
  task automatic async_reset();
    in_t idle;
    idle = '{default: 0};
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset();
    rst = 1'b0;
    m0 = minit();
    m1 = minit();
    drive(idle);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("u0.posX", int'(b0.posX), e0.x);
        chk("u0.posY", int'(b0.posY), e0.y);
        chk("u0.dir_x", int'(b0.dir_x), e0.dx);
        chk("u0.dir_y", int'(b0.dir_y), e0.dy);
        chk("u0.moving", int'(b0.moving), e0.mv);
        chk("u0.wrapped", int'(b0.wrapped), e0.wr);
        chk("u0.size", int'(b0.size), 13);
      end
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("u1.posX", int'(b1.posX), e1.x);
        chk("u1.posY", int'(b1.posY), e1.y);
        chk("u1.dir_x", int'(b1.dir_x), e1.dx);
        chk("u1.dir_y", int'(b1.dir_y), e1.dy);
        chk("u1.moving", int'(b1.moving), e1.mv);
        chk("u1.wrapped", int'(b1.wrapped), e1.wr);
      end
    end
  end

  initial begin
    in_t     ri;
    bit [7:0] hold_key;
    int      sel;
    cur_in = '{default: 0};
    b0.restart = 0; b0.lifeDown = 0; b0.freeze = 0; b0.keycode = 0;
    b0.mapL = 0; b0.mapR = 0; b0.mapB = 0; b0.mapT = 0;
    b1.restart = 0; b1.lifeDown = 0; b1.freeze = 0; b1.keycode = 0;
    b1.mapL = 0; b1.mapR = 0; b1.mapB = 0; b1.mapT = 0;
    repeat (2) @(negedge clk);
    async_reset();

    // Straight right from spawn.
    for (int k = 0; k < 5; k++) apply(0, 0, 0, 8'h07, 0, 0, 0, 0);
    // Queued turn up against a closed cell, then it opens.
    apply(0, 0, 0, 8'h07, 0, 0, 0, 0);
    apply(0, 0, 0, 8'h1A, 0, 0, 0, 5'd1);
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 8'h00, 0, 0, 0, 5'd1);
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // Reset in the middle of motion.
    for (int k = 0; k < 3; k++) apply(0, 0, 0, 8'h04, 0, 0, 0, 0);
    async_reset();
    // Up into the tunnel row, left through the wrap, back right through it.
    for (int k = 0; k < 53; k++) apply(0, 0, 0, 8'h1A, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) apply(0, 0, 0, 8'h04, 0, 0, 0, 0);
    for (int k = 0; k < 130; k++) apply(0, 0, 0, 8'h07, 0, 0, 0, 0);
    // Frozen, then life lost while frozen with a key held.
    for (int k = 0; k < 3; k++) apply(0, 0, 1, 8'h16, 0, 0, 0, 0);
    apply(0, 1, 1, 8'h07, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) apply(0, 0, 0, 8'h07, 0, 0, 0, 0);
    apply(1, 0, 0, 8'h00, 0, 0, 0, 0);
    apply(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // Run into each maze bound.
    for (int k = 0; k < 200; k++) apply(0, 0, 0, 8'h16, 0, 0, 0, 0);
    for (int k = 0; k < 200; k++) apply(0, 0, 0, 8'h07, 0, 0, 0, 0);
    for (int k = 0; k < 520; k++) apply(0, 0, 0, 8'h04, 0, 0, 0, 0);
    for (int k = 0; k < 560; k++) apply(0, 0, 0, 8'h1A, 0, 0, 0, 0);

    // Random play.
    hold_key = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          sel = $urandom_range(0, 6);
          case (sel)
            0: hold_key = 8'h04;
            1: hold_key = 8'h07;
            2: hold_key = 8'h16;
            3: hold_key = 8'h1A;
            4: hold_key = 8'h00;
            default: hold_key = 8'($urandom_range(0, 255));
          endcase
        end
        ri.rs = ($urandom_range(0, 149) == 0);
        ri.ld = ($urandom_range(0, 149) == 0);
        ri.fz = ($urandom_range(0, 15) == 0);
        ri.key = ($urandom_range(0, 5) == 0) ? 8'h00 : hold_key;
        ri.ml = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        ri.mr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        ri.mb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        ri.mt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        @(negedge clk);
        drive(ri);
      end
    end

    @(negedge clk);
    @(posedge clk);
    #3;
    chk("u0.drain", q0.size(), 0);
    chk("u1.drain", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
